vga_view_compositor: RTL and testbench
======================================

// Module: vga_view_compositor
// PURPOSE
//  Next-gen VGA display engine for the image accelerator: generates parametrised VGA timing and composites
//  source-image ROM and result RAM into one frame, in one of three view modes. Highlights the selected tile
//  of a GRIDxGRID source partition and latches mode/tile only at frame boundaries (no tearing).
//  Sits between drom/dram read ports and the DAC pins; runs on the 50 MHz system clock with an internal pixel enable.
// PARAMETERS
//  H_ACT 640, H_FP 16, H_SYN 96, H_BP 48   horizontal timing in pixels; hsync active-low
//  V_ACT 480, V_FP 10, V_SYN 2,  V_BP 33   vertical timing in lines; vsync active-low
//  IMG_W 256, IMG_H 256                    stored image size in pixels, 8-bit grey, row-major
//  GRID 2                                  tiles per side; tile count is GRID*GRID
//  RES_BASE 6                              word offset added to every result-RAM address
//  PIX_DIV 2                               system clocks per pixel; must be >= 2
//  MEM_LAT 1                               ROM/RAM read latency in clocks; must be < PIX_DIV
//  ADDR_W  $clog2(IMG_W*IMG_H)             derived memory address width
// PORTS
//  clock       in   1       system clock (50 MHz)
//  reset       in   1       asynchronous, active-low
//  enable      in   1       0: outputs blanked, counters held at 0
//  mode        in   2       0 SRC, 1 RES, 2 SPLIT (src left, result right), 3 reserved (treated as SRC)
//  tile        in   $clog2(GRID*GRID)  selected tile index, row-major
//  rom_addr    out  ADDR_W  source ROM read address
//  rom_data    in   8       source ROM pixel, valid MEM_LAT clocks after rom_addr
//  ram_addr    out  ADDR_W  result RAM read address (already includes RES_BASE)
//  ram_data    in   8       result RAM pixel, same latency as rom_data
//  red/green/blue out 8     pixel colour
//  hsync/vsync out  1       sync outputs, active-low
//  n_blank     out  1       1 inside the active area
//  pix_ce      out  1       pixel enable; drives vgaclock-qualified logic
//  frame_start out  1       one-clock pulse when a new frame's mode/tile is latched
// BEHAVIOUR
//  - Reset: all counters 0; rgb 0; hsync=vsync=1; n_blank=0; addrs 0; pix_ce=0; frame_start=0; latched mode=SRC, tile=0.
//  - pix_ce: divider counter; asserts for 1 clock every PIX_DIV clocks. All state below advances only on pix_ce.
//  - Counters: hc wraps at H_ACT+H_FP+H_SYN+H_BP-1 to 0 and increments vc; vc wraps at V_total-1 to 0.
//  - Frame latch: on the pix_ce where hc=0,vc=0, sample mode and tile into the shadow regs and pulse frame_start.
//    Mid-frame changes are ignored until the next frame. tile >= GRID*GRID is clamped to GRID*GRID-1.
//  - Geometry: image is centred; x0=(H_ACT-IMG_W)/2, y0=(V_ACT-IMG_H)/2. In SPLIT, src x0=H_ACT/2-IMG_W and
//    result x0=H_ACT/2; on overlap, result wins. Pixels outside all image windows are black.
//  - Addressing: addr=(y-y0)*IMG_W+(x-x0), computed with ADDR_W-bit truncation. ram_addr adds RES_BASE modulo 2^ADDR_W.
//    Outside a window, the address holds its last value.
//  - Pipeline: stage0 counters -> stage1 address regs -> stage2 data capture. Data is sampled on the next pix_ce.
//    hsync, vsync, n_blank, window select and border flag are delayed 2 pix_ce so every output is aligned.
//    Total latency from counter to pin is 2 pixels.
//  - Colour: grey g -> {g,g,g}. Border: a 1-pixel outline of the latched tile in the source window is
//    forced to {FF,00,00}. Tile width is IMG_W/GRID; integer division with remainder goes to the last tile.
//  - Sync: hsync is low for hc in [H_ACT+H_FP, H_ACT+H_FP+H_SYN). vsync is defined the same way on vc.
//  - enable=0: counters reset to 0 synchronously; outputs are as in reset, except pix_ce keeps running.
//  - Reset mid-frame: immediate return to reset values. The first frame after release begins at hc=vc=0 with frame_start.
// STRUCTURE
//  - vga_pkg: view_mode_t enum (SRC, RES, SPLIT); default timing localparams; border colour constant.
//  - Sub-module vga_timing_gen: divider, hc/vc counters, raw sync/active flags, frame-boundary pulse.
//  - The top holds the window/tile decode, address math, 2-stage alignment pipeline and colour mux.
// TESTING
//  1 Reset low for 3 clocks, then high -> all outputs at reset values; first frame_start at clock PIX_DIV*1.
//  2 Defaults, free run one frame -> 800 pixels/line, 525 lines/frame; hsync low 96 pixels, vsync low 2 lines;
//    420000 pix_ce between frame_starts.
//  3 mode=SRC, model ROM data=addr[7:0] -> pixel (x=192,y=112) shows 00, (x=193,y=112) shows 01;
//    both 2 pixels after the counter, with n_blank aligned.
//  4 mode=SPLIT -> the right-window pixel at (320,112) requests ram_addr=6 and outputs the RAM model value;
//    the left pixel at (64,112) requests rom_addr=0.
//  5 tile=3, GRID=2 -> red border at src x in {128,255}, y in {128,255} within the image.
//    Changing tile to 0 mid-frame has no effect until the next frame_start.
//  6 enable dropped mid-line for 10 clocks -> rgb=0, syncs high; on re-enable the counters restart at 0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: view modes, default VGA timing and overlay colour shared by the compositor.
package vga_pkg;

    typedef enum logic [1:0] {SRC = 2'd0, RES = 2'd1, SPLIT = 2'd2} view_mode_t;

    localparam int DEF_H_ACT = 640;
    localparam int DEF_H_FP = 16;
    localparam int DEF_H_SYN = 96;
    localparam int DEF_H_BP = 48;
    localparam int DEF_V_ACT = 480;
    localparam int DEF_V_FP = 10;
    localparam int DEF_V_SYN = 2;
    localparam int DEF_V_BP = 33;

    localparam logic [23:0] BORDER_RGB = 24'hFF0000;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-enable divider, hc/vc raster counters, raw sync/active flags
// and the frame-boundary tick used to latch per-frame settings.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACT = DEF_H_ACT,
    parameter int H_FP = DEF_H_FP,
    parameter int H_SYN = DEF_H_SYN,
    parameter int H_BP = DEF_H_BP,
    parameter int V_ACT = DEF_V_ACT,
    parameter int V_FP = DEF_V_FP,
    parameter int V_SYN = DEF_V_SYN,
    parameter int V_BP = DEF_V_BP,
    parameter int PIX_DIV = 2,
    parameter int HW = clog2_min1(H_ACT + H_FP + H_SYN + H_BP),
    parameter int VW = clog2_min1(V_ACT + V_FP + V_SYN + V_BP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    output logic          pix_ce,
    output logic [HW-1:0] hc,
    output logic [VW-1:0] vc,
    output logic          hs_raw,
    output logic          vs_raw,
    output logic          act_raw,
    output logic          frame_tick
);

    localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;
    localparam int DW = clog2_min1(PIX_DIV);

    logic [DW-1:0] div;
    logic h_end, v_end;

    assign pix_ce = (div == DW'(PIX_DIV - 1));
    assign h_end = (hc == HW'(H_TOT - 1));
    assign v_end = (vc == VW'(V_TOT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div <= '0;
        else div <= pix_ce ? '0 : div + 1'b1;
    end

    // The divider free-runs through enable=0; only the raster is held at the origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
            vc <= '0;
        end else if (!enable) begin
            hc <= '0;
            vc <= '0;
        end else if (pix_ce) begin
            hc <= h_end ? '0 : hc + 1'b1;
            if (h_end) vc <= v_end ? '0 : vc + 1'b1;
        end
    end

    assign hs_raw = !(hc >= HW'(H_ACT + H_FP) && hc < HW'(H_ACT + H_FP + H_SYN));
    assign vs_raw = !(vc >= VW'(V_ACT + V_FP) && vc < VW'(V_ACT + V_FP + V_SYN));
    assign act_raw = (hc < HW'(H_ACT)) && (vc < VW'(V_ACT));
    assign frame_tick = pix_ce && enable && hc == '0 && vc == '0;

endmodule

// File: rtl/vga_view_compositor.sv
// vga_view_compositor: composites source ROM and result RAM into a VGA raster with a
// per-frame view mode and a highlighted source tile, two pixels from counter to pin.
module vga_view_compositor
    import vga_pkg::*;
#(
    parameter int H_ACT = DEF_H_ACT,
    parameter int H_FP = DEF_H_FP,
    parameter int H_SYN = DEF_H_SYN,
    parameter int H_BP = DEF_H_BP,
    parameter int V_ACT = DEF_V_ACT,
    parameter int V_FP = DEF_V_FP,
    parameter int V_SYN = DEF_V_SYN,
    parameter int V_BP = DEF_V_BP,
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int GRID = 2,
    parameter int RES_BASE = 6,
    parameter int PIX_DIV = 2,
    parameter int MEM_LAT = 1,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H),
    parameter int TILE_W = clog2_min1(GRID * GRID)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [TILE_W-1:0] tile,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_data,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              hsync,
    output logic              vsync,
    output logic              n_blank,
    output logic              pix_ce,
    output logic              frame_start
);

    localparam int HW = clog2_min1(H_ACT + H_FP + H_SYN + H_BP);
    localparam int VW = clog2_min1(V_ACT + V_FP + V_SYN + V_BP);
    localparam int TILES = GRID * GRID;
    localparam int TW = IMG_W / GRID;
    localparam int TH = IMG_H / GRID;
    localparam int X0 = (H_ACT - IMG_W) / 2;
    localparam int Y0 = (V_ACT - IMG_H) / 2;

    // Data is captured on the pix_ce after the address, so memory must answer within one pixel.
    if (PIX_DIV < 2 || MEM_LAT >= PIX_DIV) begin : g_bad_cfg
        $error("vga_view_compositor: need PIX_DIV >= 2 and MEM_LAT < PIX_DIV");
    end

    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic hs_raw, vs_raw, act_raw, frame_tick;

    vga_timing_gen #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYN(H_SYN), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYN(V_SYN), .V_BP(V_BP),
        .PIX_DIV(PIX_DIV), .HW(HW), .VW(VW)
    ) u_timing (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pix_ce(pix_ce),
        .hc(hc), .vc(vc), .hs_raw(hs_raw), .vs_raw(vs_raw),
        .act_raw(act_raw), .frame_tick(frame_tick)
    );

    view_mode_t mode_q;
    logic [TILE_W-1:0] tile_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= SRC;
            tile_q <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_tick;
            if (frame_tick) begin
                mode_q <= (mode == 2'd3) ? SRC : view_mode_t'(mode);
                tile_q <= (int'(tile) >= TILES) ? TILE_W'(TILES - 1) : tile;
            end
        end
    end

    int x, y, sx0, rx0, lx, rlx, ly, tc, tr, txs, txe, tys, tye;
    logic in_y, src_on, res_on, border;
    logic [ADDR_W-1:0] src_a, res_a;

    assign x = int'(hc);
    assign y = int'(vc);

    always_comb begin
        sx0 = (mode_q == SPLIT) ? H_ACT / 2 - IMG_W : X0;
        rx0 = (mode_q == SPLIT) ? H_ACT / 2 : X0;
        lx = x - sx0;
        rlx = x - rx0;
        ly = y - Y0;
        in_y = ly >= 0 && ly < IMG_H;
        src_on = mode_q != RES && in_y && lx >= 0 && lx < IMG_W;
        res_on = mode_q != SRC && in_y && rlx >= 0 && rlx < IMG_W;
        tc = int'(tile_q) % GRID;
        tr = int'(tile_q) / GRID;
        txs = tc * TW;
        tys = tr * TH;
        txe = (tc == GRID - 1) ? IMG_W - 1 : txs + TW - 1;
        tye = (tr == GRID - 1) ? IMG_H - 1 : tys + TH - 1;
        border = src_on && lx >= txs && lx <= txe && ly >= tys && ly <= tye &&
                 (lx == txs || lx == txe || ly == tys || ly == tye);
        src_a = ADDR_W'(ly * IMG_W + lx);
        res_a = ADDR_W'(ly * IMG_W + rlx + RES_BASE);
    end

    logic hs1, vs1, act1, src1, res1, bord1;

    // Stage 1 issues addresses and delays flags; stage 2 muxes returned data onto the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {rom_addr, ram_addr, act1, src1, res1, bord1, n_blank, red, green, blue} <= '0;
            {hs1, vs1, hsync, vsync} <= '1;
        end else if (!enable) begin
            {rom_addr, ram_addr, act1, src1, res1, bord1, n_blank, red, green, blue} <= '0;
            {hs1, vs1, hsync, vsync} <= '1;
        end else if (pix_ce) begin
            if (src_on) rom_addr <= src_a;
            if (res_on) ram_addr <= res_a;
            hs1 <= hs_raw;
            vs1 <= vs_raw;
            act1 <= act_raw;
            src1 <= src_on && !res_on;
            res1 <= res_on;
            bord1 <= border && !res_on;
            hsync <= hs1;
            vsync <= vs1;
            n_blank <= act1;
            {red, green, blue} <= res1 ? {3{ram_data}} : !src1 ? 24'h0 :
                                  bord1 ? BORDER_RGB : {3{rom_data}};
        end
    end

endmodule

// File: tb/tb_vga_view_compositor.sv
// tb_vga_view_compositor: randomized per-frame modes/tiles on a shrunken raster, every
// pixel and address compared against a geometric reference model of the view rules.
module tb_vga_view_compositor;

    localparam int H_ACT = 64, H_FP = 4, H_SYN = 8, H_BP = 4;
    localparam int V_ACT = 40, V_FP = 2, V_SYN = 2, V_BP = 2;
    localparam int IMG_W = 16, IMG_H = 16, GRID = 3, RES_BASE = 6, PIX_DIV = 2;
    localparam int HT = H_ACT + H_FP + H_SYN + H_BP;
    localparam int VT = V_ACT + V_FP + V_SYN + V_BP;
    localparam int FRAME_PX = HT * VT;
    localparam int Y0 = (V_ACT - IMG_H) / 2;

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [3:0] tile = 4'd0;
    logic [7:0] rom_addr, ram_addr, rom_data = 8'h0, ram_data = 8'h0;
    logic [7:0] red, green, blue;
    logic hsync, vsync, n_blank, pix_ce, frame_start;

    int checks = 0, errors = 0;

    vga_view_compositor #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYN(H_SYN), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYN(V_SYN), .V_BP(V_BP),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .GRID(GRID), .RES_BASE(RES_BASE),
        .PIX_DIV(PIX_DIV), .MEM_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .tile(tile),
        .rom_addr(rom_addr), .rom_data(rom_data), .ram_addr(ram_addr), .ram_data(ram_data),
        .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
        .n_blank(n_blank), .pix_ce(pix_ce), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [7:0] a);
        return a;
    endfunction

    function automatic logic [7:0] ram_f(input logic [7:0] a);
        return 8'(a * 5 + 17);
    endfunction

    always @(posedge clk) begin
        rom_data <= rom_f(rom_addr);
        ram_data <= ram_f(ram_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void geom(input int p, input int m, output bit s, output bit r,
                                 output int sa, output int ra);
        int x = p % HT, y = p / HT;
        int sx0 = (m == 2) ? H_ACT / 2 - IMG_W : (H_ACT - IMG_W) / 2;
        int rx0 = (m == 2) ? H_ACT / 2 : (H_ACT - IMG_W) / 2;
        bit iy = y >= Y0 && y < Y0 + IMG_H;
        s = m != 1 && iy && x >= sx0 && x < sx0 + IMG_W;
        r = m != 0 && iy && x >= rx0 && x < rx0 + IMG_W;
        sa = (y - Y0) * IMG_W + x - sx0;
        ra = ((y - Y0) * IMG_W + x - rx0 + RES_BASE) % 256;
    endfunction

    function automatic logic [26:0] exp_pix(input int p, input int m, input int t);
        int x = p % HT, y = p / HT, sa, ra, lx, ly, xs, xe, ys, ye;
        bit s, r, bd, hs, vs, nb;
        logic [23:0] rgb;
        geom(p, m, s, r, sa, ra);
        lx = sa % IMG_W;
        ly = sa / IMG_W;
        xs = (t % GRID) * (IMG_W / GRID);
        ys = (t / GRID) * (IMG_H / GRID);
        xe = (t % GRID == GRID - 1) ? IMG_W - 1 : xs + IMG_W / GRID - 1;
        ye = (t / GRID == GRID - 1) ? IMG_H - 1 : ys + IMG_H / GRID - 1;
        bd = lx >= xs && lx <= xe && ly >= ys && ly <= ye &&
             (lx == xs || lx == xe || ly == ys || ly == ye);
        rgb = r ? {3{ram_f(8'(ra))}} : !s ? 24'h0 : bd ? 24'hFF0000 : {3{rom_f(8'(sa))}};
        hs = !(x >= H_ACT + H_FP && x < H_ACT + H_FP + H_SYN);
        vs = !(y >= V_ACT + V_FP && y < V_ACT + V_FP + V_SYN);
        nb = x < H_ACT && y < V_ACT;
        return {rgb, hs, vs, nb};
    endfunction

    int k = 0, lm = 0, lt = 0, pm = 0, pt = 0, exp_rom = 0, exp_ram = 0;
    bit valid = 0, last_ce = 0;

    // k counts pix_ce edges since the frame latch: addresses show pixel k, pins show pixel k-1.
    always @(negedge clk) begin
        bit was_ce, s, r;
        int sa, ra;
        was_ce = last_ce;
        last_ce = pix_ce;
        if (!rst_n || !enable) begin
            valid = 0;
            exp_rom = 0;
            exp_ram = 0;
        end else if (frame_start) begin
            if (valid) check("frame_period", 32'(k + 1), 32'(FRAME_PX));
            valid = 1;
            k = 0;
            lm = pm;
            lt = pt;
        end else if (valid && was_ce) k++;
        if (rst_n && enable && valid && (frame_start || was_ce)) begin
            geom(k, lm, s, r, sa, ra);
            if (s) exp_rom = sa;
            if (r) exp_ram = ra;
            check("rom_addr", 32'(rom_addr), 32'(exp_rom));
            check("ram_addr", 32'(ram_addr), 32'(exp_ram));
            if (k >= 1) check("pixel", 32'({red, green, blue, hsync, vsync, n_blank}),
                              32'(exp_pix(k - 1, lm, lt)));
        end
        pm = (mode == 2'd3) ? 0 : int'(mode);
        pt = (tile >= 4'd9) ? 8 : int'(tile);
    end

    task automatic wait_frame();
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!frame_start && n < 2 * FRAME_PX * PIX_DIV);
        check("frame_wait", 32'(frame_start), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_pix"}, 32'({red, green, blue, hsync, vsync, n_blank, frame_start}),
              32'({24'h0, 4'b1100}));
        check({tag, "_addr"}, 32'({rom_addr, ram_addr}), 32'd0);
    endtask

    int mode_tab[4] = '{2, 1, 0, 3};
    int tile_tab[4] = '{4, 0, 8, 13};

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset_pix_ce", 32'(pix_ce), 32'd0);
        rst_n = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!frame_start && n < 20);
        check("first_frame_start", 32'(n), 32'(PIX_DIV));
        for (int f = 0; f < 4; f++) begin
            mode = 2'(mode_tab[f]);
            tile = 4'(tile_tab[f]);
            wait_frame();
            repeat (3) begin
                repeat ($urandom_range(200, 2000)) @(posedge clk);
                #1;
                mode = 2'($urandom_range(0, 3));
                tile = 4'($urandom_range(0, 15));
            end
        end
        repeat ($urandom_range(100, 600)) @(posedge clk);
        #1 enable = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_idle("disable");
        enable = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!frame_start && n < 10);
        check("reenable_frame_start", 32'(n <= PIX_DIV && frame_start), 32'd1);
        mode = 2'd2;
        tile = 4'd15;
        wait_frame();
        repeat ($urandom_range(500, 3000)) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_idle("midframe_reset");
        check("midframe_reset_pix_ce", 32'(pix_ce), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!frame_start && n < 20);
        check("restart_frame_start", 32'(n), 32'(PIX_DIV));
        repeat (3000) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
